// File: rtl/rx_packet_parser.sv
// rtl/rx_packet_parser.sv - byte-stream deframer, packet FIFO and pipeline round issuer (optional RX_CHECKSUM_EN)
module rx_packet_parser #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clock,
    input  logic                          nrst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic                          done_pipeline,
    output logic                          start,
    output logic [15:0]                   fsourceID,
    output logic [15:0]                   fdestinationID,
    output logic [15:0]                   fbatteryStat,
    output logic [15:0]                   fValue,
    output logic [15:0]                   fclusterID,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
`ifdef RX_CHECKSUM_EN
    localparam int SR_W = 80;
`else
    localparam int SR_W = 72;
`endif

    typedef enum logic [1:0] {HUNT = 2'd0, FIELD = 2'd1, CSUM = 2'd2} pstate_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} istate_t;

    pstate_t           p_state, p_next;
    istate_t           i_state, i_next;
    logic [3:0]        idx;
    logic [SR_W-1:0]   shreg;
    logic              accept, push, pop, rearm;
    logic [79:0]       push_data;
    logic [79:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
`ifdef RX_CHECKSUM_EN
    logic [7:0]        csum;
    logic              drop;
`endif

    assign rx_ready   = (count != FULL_COUNT);
    assign accept     = rx_valid && rx_ready;
    assign fifo_count = count;

    // Parser state register
    always_ff @(posedge clock) begin
        if (nrst) p_state <= HUNT;
        else      p_state <= p_next;
    end

    // Parser next state: sync hunt, ten field bytes, optional checksum byte
    always_comb begin
        p_next = p_state;
        if (accept) begin
            case (p_state)
                HUNT:    if (rx_data == SYNC_BYTE) p_next = FIELD;
                FIELD:   if (idx == 4'd9) begin
`ifdef RX_CHECKSUM_EN
                             p_next = CSUM;
`else
                             p_next = HUNT;
`endif
                         end
                default: p_next = HUNT;
            endcase
        end
    end

    // Parser outputs: commit on the edge the final byte is accepted
    always_comb begin
        push = 1'b0;
`ifdef RX_CHECKSUM_EN
        drop      = 1'b0;
        push_data = shreg;
`else
        push_data = {shreg, rx_data};
`endif
        if (accept) begin
            case (p_state)
`ifdef RX_CHECKSUM_EN
                CSUM: begin
                    if (rx_data == csum) push = 1'b1;
                    else                 drop = 1'b1;
                end
`else
                FIELD: push = (idx == 4'd9);
`endif
                default: ;
            endcase
        end
    end

    // Field byte collection: bytes shift in from the bottom, so byte 0 ends up most significant
    always_ff @(posedge clock) begin
        if (nrst) begin
            idx   <= 4'd0;
            shreg <= '0;
`ifdef RX_CHECKSUM_EN
            csum  <= 8'd0;
`endif
        end else if (accept) begin
            if (p_state == HUNT) begin
                idx  <= 4'd0;
`ifdef RX_CHECKSUM_EN
                csum <= 8'd0;
`endif
            end else if (p_state == FIELD) begin
                idx   <= idx + 4'd1;
                shreg <= {shreg[SR_W-9:0], rx_data};
`ifdef RX_CHECKSUM_EN
                csum  <= csum ^ rx_data;
`endif
            end
        end
    end

`ifdef RX_CHECKSUM_EN
    // Saturating count of checksum failures
    always_ff @(posedge clock) begin
        if (nrst)                                drop_count <= 16'd0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`else
    assign drop_count = 16'd0;
`endif

    // Issue state register; rearm forces one idle cycle after each round
    always_ff @(posedge clock) begin
        if (nrst) begin
            i_state <= IDLE;
            rearm   <= 1'b0;
        end else begin
            i_state <= i_next;
            rearm   <= (i_state == BUSY) && (i_next == IDLE);
        end
    end

    // Issue next state: start a round when a packet is waiting, end it on done
    always_comb begin
        i_next = i_state;
        case (i_state)
            IDLE:    if (count != '0 && !rearm) i_next = BUSY;
            BUSY:    if (done_pipeline) i_next = IDLE;
            default: i_next = IDLE;
        endcase
    end

    // Issue outputs
    always_comb begin
        start = (i_state == BUSY);
        pop   = (i_state == IDLE) && (i_next == BUSY);
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and field output registers
    always_ff @(posedge clock) begin
        if (nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            {fsourceID, fdestinationID, fbatteryStat, fValue, fclusterID} <= 80'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {fsourceID, fdestinationID, fbatteryStat, fValue, fclusterID} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_packet_parser.sv
// tb/tb_rx_packet_parser.sv - randomized self-checking bench for rx_packet_parser
module tb_rx_packet_parser;
    logic        clock = 1'b0;
    logic        nrst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        done_pipeline = 1'b0;
    logic        start;
    logic [15:0] fsourceID, fdestinationID, fbatteryStat, fValue, fclusterID;
    logic [2:0]  fifo_count;
    logic [15:0] drop_count;

    int passed = 0;
    int total = 0;
    int gap_max = 0;
    int exp_drop = 0;
    logic [79:0] expq[$];

    rx_packet_parser #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clock(clock), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .done_pipeline(done_pipeline), .start(start),
        .fsourceID(fsourceID), .fdestinationID(fdestinationID),
        .fbatteryStat(fbatteryStat), .fValue(fValue), .fclusterID(fclusterID),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [79:0] fields();
        return {fsourceID, fdestinationID, fbatteryStat, fValue, fclusterID};
    endfunction

    function automatic logic [79:0] rand_pkt();
        logic [31:0] a, b, c;
        a = $urandom();
        b = $urandom();
        c = $urandom();
        return {a, b, c[15:0]};
    endfunction

    function automatic logic [7:0] frame_csum(input logic [79:0] p);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < 10; i++) x = x ^ p[79-8*i -: 8];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        int gap;
        gap = $urandom_range(0, gap_max);
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 300) begin
            tick();
            guard++;
        end
        if (!rx_ready) begin
            total++;
            $display("FAIL rx_ready_timeout got=0 exp=1");
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] p, input bit bad);
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(p[79-8*i -: 8]);
`ifdef RX_CHECKSUM_EN
        send_byte(frame_csum(p) ^ (bad ? 8'h04 : 8'h00));
`endif
    endtask

    task automatic pulse_done(input string tag);
        done_pipeline = 1'b1;
        tick();
        done_pipeline = 1'b0;
        total++;
        if (start !== 1'b0) $display("FAIL %s_start_drop got=%b exp=0", tag, start); else passed++;
    endtask

    task automatic check_issue(input string tag, input logic [79:0] p);
        total++;
        if (fifo_count !== 3'd1) $display("FAIL %s_count_n got=%0d exp=1", tag, fifo_count); else passed++;
        tick();
        total++;
        if (start !== 1'b1) $display("FAIL %s_start got=%b exp=1", tag, start); else passed++;
        total++;
        if (fields() !== p) $display("FAIL %s_fields got=%h exp=%h", tag, fields(), p); else passed++;
        total++;
        if (fifo_count !== 3'd0) $display("FAIL %s_count_n1 got=%0d exp=0", tag, fifo_count); else passed++;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (start !== 1'b0) $display("FAIL %s_start got=%b exp=0", tag, start); else passed++;
        total++;
        if (fields() !== 80'd0) $display("FAIL %s_fields got=%h exp=0", tag, fields()); else passed++;
        total++;
        if (fifo_count !== 3'd0) $display("FAIL %s_count got=%0d exp=0", tag, fifo_count); else passed++;
        total++;
        if (drop_count !== 16'd0) $display("FAIL %s_drop got=%0d exp=0", tag, drop_count); else passed++;
        total++;
        if (rx_ready !== 1'b1) $display("FAIL %s_ready got=%b exp=1", tag, rx_ready); else passed++;
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        repeat (2) tick();
        nrst = 1'b0;
        tick();
        check_reset_values("reset");
    endtask

    task automatic test_single();
        logic [79:0] p = 80'h0001_0003_0001_000A_0001;
        send_frame(p, 1'b0);
        check_issue("single", p);
        pulse_done("single");
    endtask

    task automatic test_bad_checksum();
        logic [79:0] p = 80'h0001_0003_0001_000A_0001;
        logic [79:0] q;
`ifdef RX_CHECKSUM_EN
        send_frame(p, 1'b1);
        exp_drop++;
        repeat (5) tick();
        total++;
        if (start !== 1'b0) $display("FAIL badcsum_start got=%b exp=0", start); else passed++;
        total++;
        if (fifo_count !== 3'd0) $display("FAIL badcsum_count got=%0d exp=0", fifo_count); else passed++;
`else
        q = p ^ 80'h0000_0000_00FF_0000_0000;
        send_frame(q, 1'b0);
        check_issue("corrupt", q);
        pulse_done("corrupt");
`endif
        total++;
        if (drop_count !== 16'(exp_drop)) $display("FAIL badcsum_drop got=%0d exp=%0d", drop_count, exp_drop); else passed++;
        q = rand_pkt();
        send_frame(q, 1'b0);
        check_issue("after_bad", q);
        pulse_done("after_bad");
    endtask

    task automatic test_garbage();
        logic [79:0] p = rand_pkt();
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(p, 1'b0);
        check_issue("garbage", p);
        total++;
        if (drop_count !== 16'(exp_drop)) $display("FAIL garbage_drop got=%0d exp=%0d", drop_count, exp_drop); else passed++;
        pulse_done("garbage");
    endtask

    task automatic drain(input int n);
        int lows;
        logic [79:0] e;
        for (int k = 0; k < n; k++) begin
            e = expq.pop_front();
            total++;
            if (start !== 1'b1) $display("FAIL b2b_start_%0d got=%b exp=1", k, start); else passed++;
            total++;
            if (fields() !== e) $display("FAIL b2b_fields_%0d got=%h exp=%h", k, fields(), e); else passed++;
            pulse_done("b2b");
            if (k < n - 1) begin
                lows = 1;
                while (!start && lows < 100) begin
                    tick();
                    lows++;
                end
                total++;
                if (!(start === 1'b1 && lows >= 2)) $display("FAIL b2b_gap_%0d got=%0d exp=>=2", k, lows); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] p [6];
        gap_max = 0;
        for (int i = 0; i < 6; i++) begin
            p[i] = rand_pkt();
            expq.push_back(p[i]);
        end
        for (int i = 0; i < 5; i++) send_frame(p[i], 1'b0);
        total++;
        if (fifo_count !== 3'd4) $display("FAIL b2b_full_count got=%0d exp=4", fifo_count); else passed++;
        total++;
        if (rx_ready !== 1'b0) $display("FAIL b2b_ready got=%b exp=0", rx_ready); else passed++;
        fork
            send_frame(p[5], 1'b0);
            drain(6);
        join
        total++;
        if (fifo_count !== 3'd0) $display("FAIL b2b_empty got=%0d exp=0", fifo_count); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [79:0] p;
        gap_max = 0;
        for (int i = 0; i < 3; i++) send_frame(rand_pkt(), 1'b0);
        total++;
        if (fifo_count !== 3'd2) $display("FAIL rstmid_count got=%0d exp=2", fifo_count); else passed++;
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        exp_drop = 0;
        expq.delete();
        check_reset_values("rstmid");
        p = rand_pkt();
        send_frame(p, 1'b0);
        check_issue("rstmid_clean", p);
        pulse_done("rstmid");
    endtask

    task automatic test_random();
        logic [79:0] p;
        bit bad;
        gap_max = 2;
        for (int n = 0; n < 12; n++) begin
            p = rand_pkt();
`ifdef RX_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`else
            bad = 1'b0;
`endif
            send_frame(p, bad);
            if (!bad) begin
                check_issue("rand", p);
                pulse_done("rand");
            end else begin
                exp_drop++;
                tick();
                total++;
                if (start !== 1'b0) $display("FAIL rand_bad_start got=%b exp=0", start); else passed++;
            end
            total++;
            if (drop_count !== 16'(exp_drop)) $display("FAIL rand_drop got=%0d exp=%0d", drop_count, exp_drop); else passed++;
        end
        gap_max = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_checksum();
        test_garbage();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
